// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage_if
//  Purpose  : Bundles the fetch-stage signals: hazard/redirect controls,
//             instruction-memory read port and the IF/ID register outputs.
//  Modports : master - the fetch stage (drives imem_*, id_*, misalign_err)
//             slave  - its surroundings (hazard unit, EX, imem, decode)
//  Revision : 1.0 - initial release
// ============================================================================
interface if_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        misalign_err;

    modport master (
        input  stall, redirect, redirect_pc, imem_rdata,
        output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
               misalign_err
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rdata,
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
               misalign_err
    );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : rv32i instruction fetch stage with IF/ID pipeline register.
//             Drives a synchronous instruction memory (1-cycle read latency),
//             handles hazard stalls via a 1-entry hold buffer and branch/jump
//             redirects from EX.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - if_stage_if.master (stall, redirect, redirect_pc,
//                    imem_req/addr/rdata, id_valid/instr/pc/pc_plus4,
//                    misalign_err)
//  Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  wire logic         clk,
    input  wire logic         rst,
    if_stage_if.master        bus
);

    // Fetch side
    logic [31:0] r_pc;
    logic        r_pend;       // a read response is on imem_rdata this cycle
    logic [31:0] r_pend_pc;

    // Hold buffer: catches the one response that lands during a stall
    logic        r_hold_v;
    logic [31:0] r_hold_buf;
    logic [31:0] r_hold_pc;

    // IF/ID register
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc_plus4;
    logic        r_misalign;

    logic        w_req;

    assign w_req              = !rst && !bus.stall && !bus.redirect;
    assign bus.imem_req       = w_req;
    assign bus.imem_addr      = r_pc;
    assign bus.id_valid       = r_id_valid;
    assign bus.id_instr       = r_id_valid ? r_id_instr : NOP_INSTR;
    assign bus.id_pc          = r_id_pc;
    assign bus.id_pc_plus4    = r_id_pc_plus4;
    assign bus.misalign_err   = r_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_pend        <= 1'b0;
            r_pend_pc     <= 32'h0;
            r_hold_v      <= 1'b0;
            r_hold_buf    <= 32'h0;
            r_hold_pc     <= 32'h0;
            r_id_valid    <= 1'b0;
            r_id_instr    <= NOP_INSTR;
            r_id_pc       <= 32'h0;
            r_id_pc_plus4 <= 32'h0;
            r_misalign    <= 1'b0;
        end else begin
            r_misalign <= bus.redirect && (bus.redirect_pc[1:0] != 2'b00);

            if (bus.redirect) begin
                // Drops any in-flight response and any held entry.
                r_pc       <= {bus.redirect_pc[31:2], 2'b00};
                r_pend     <= 1'b0;
                r_hold_v   <= 1'b0;
                r_id_valid <= 1'b0;
            end else begin
                if (w_req) begin
                    r_pend    <= 1'b1;
                    r_pend_pc <= r_pc;
                    r_pc      <= r_pc + 32'd4;
                end else begin
                    r_pend    <= 1'b0;
                end

                if (bus.stall) begin
                    // No request issues while stalled, so only the response
                    // already in flight needs catching.
                    if (r_pend) begin
                        r_hold_buf <= bus.imem_rdata;
                        r_hold_pc  <= r_pend_pc;
                        r_hold_v   <= 1'b1;
                    end
                end else if (r_hold_v) begin
                    r_id_instr    <= r_hold_buf;
                    r_id_pc       <= r_hold_pc;
                    r_id_pc_plus4 <= r_hold_pc + 32'd4;
                    r_id_valid    <= 1'b1;
                    r_hold_v      <= 1'b0;
                end else if (r_pend) begin
                    r_id_instr    <= bus.imem_rdata;
                    r_id_pc       <= r_pend_pc;
                    r_id_pc_plus4 <= r_pend_pc + 32'd4;
                    r_id_valid    <= 1'b1;
                end else begin
                    r_id_valid    <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Directed self-checking bench for if_stage. Memory contents are
//             mem[addr] = (addr>>2)*0x10 + 0x13, read with 1-cycle latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory model
    always @(posedge clk) begin
        if (bus.imem_req)
            bus.imem_rdata <= (bus.imem_addr >> 2) * 32'h10 + 32'h13;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_rdata  = 32'h0;
        tick();
        tick();
        total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h exp=0", bus.id_valid); end
        total++; if (bus.id_instr !== 32'h13) begin bad++; $display("FAIL rst_instr got=%h exp=00000013", bus.id_instr); end
        total++; if (bus.id_pc !== 32'h0 || bus.id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h/%h exp=0/0", bus.id_pc, bus.id_pc_plus4); end
        total++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rst_req got=%h/%h exp=0/0", bus.imem_req, bus.imem_addr); end
        total++; if (bus.misalign_err !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%h exp=0", bus.misalign_err); end
        rst = 1'b0;
    endtask

    // After edge k past reset release: imem_addr=4k, IF/ID holds pc=4(k-2).
    task automatic test_stream();
        do_reset();
        tick();
        total++; if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h4) begin bad++; $display("FAIL stream_first got=%h/%h exp=0/4", bus.id_valid, bus.imem_addr); end
        for (int k = 2; k <= 6; k++) begin
            tick();
            total++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(4*(k-2)) ||
                bus.id_instr !== 32'((k-2)*16 + 19) || bus.id_pc_plus4 !== 32'(4*(k-1)) ||
                bus.imem_addr !== 32'(4*k)) begin
                bad++;
                $display("FAIL stream_k%0d got v=%h pc=%h i=%h p4=%h a=%h", k,
                         bus.id_valid, bus.id_pc, bus.id_instr, bus.id_pc_plus4, bus.imem_addr);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick(); tick();            // IF/ID=0x4, fetch of 0x8 in flight
        bus.stall = 1'b1;
        #1;
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL stall_req got=%h exp=0", bus.imem_req); end
        for (int s = 0; s < 3; s++) begin
            tick();
            total++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h4 || bus.id_instr !== 32'h23 || bus.imem_addr !== 32'hC) begin
                bad++;
                $display("FAIL stall_hold%0d got v=%h pc=%h i=%h a=%h exp=1/4/23/c", s,
                         bus.id_valid, bus.id_pc, bus.id_instr, bus.imem_addr);
            end
        end
        bus.stall = 1'b0;
        tick();
        total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h8 || bus.id_instr !== 32'h33) begin bad++; $display("FAIL stall_rel8 got v=%h pc=%h i=%h exp=1/8/33", bus.id_valid, bus.id_pc, bus.id_instr); end
        tick();
        total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'hC || bus.id_instr !== 32'h43) begin bad++; $display("FAIL stall_relC got v=%h pc=%h i=%h exp=1/c/43", bus.id_valid, bus.id_pc, bus.id_instr); end
        tick();
        total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h10 || bus.id_instr !== 32'h53) begin bad++; $display("FAIL stall_rel10 got v=%h pc=%h i=%h exp=1/10/53", bus.id_valid, bus.id_pc, bus.id_instr); end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int k = 0; k < 5; k++) tick();   // response for 0x10 pending
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        #1;
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL redir_req got=%h exp=0", bus.imem_req); end
        tick();
        bus.redirect = 1'b0;
        total++; if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h100) begin bad++; $display("FAIL redir_e0 got v=%h a=%h exp=0/100", bus.id_valid, bus.imem_addr); end
        tick();
        total++; if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h104) begin bad++; $display("FAIL redir_e1 got v=%h a=%h exp=0/104", bus.id_valid, bus.imem_addr); end
        tick();
        total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h100 || bus.id_instr !== 32'h413) begin bad++; $display("FAIL redir_e2 got v=%h pc=%h i=%h exp=1/100/413", bus.id_valid, bus.id_pc, bus.id_instr); end
        tick();
        total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h104 || bus.id_instr !== 32'h423) begin bad++; $display("FAIL redir_e3 got v=%h pc=%h i=%h exp=1/104/423", bus.id_valid, bus.id_pc, bus.id_instr); end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        tick(); tick(); tick();
        bus.stall = 1'b1;
        tick();                              // 0x8 captured into hold buffer
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        tick();
        bus.redirect = 1'b0;
        bus.stall    = 1'b0;
        total++; if (bus.id_valid !== 1'b0 || bus.id_instr !== 32'h13 || bus.imem_addr !== 32'h40) begin bad++; $display("FAIL rs_e0 got v=%h i=%h a=%h exp=0/13/40", bus.id_valid, bus.id_instr, bus.imem_addr); end
        tick();
        total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL rs_nohold got v=%h pc=%h exp=0", bus.id_valid, bus.id_pc); end
        tick();
        total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h40 || bus.id_instr !== 32'h113) begin bad++; $display("FAIL rs_e2 got v=%h pc=%h i=%h exp=1/40/113", bus.id_valid, bus.id_pc, bus.id_instr); end
    endtask

    task automatic test_misalign();
        do_reset();
        tick(); tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h103;
        tick();
        bus.redirect = 1'b0;
        total++; if (bus.misalign_err !== 1'b1 || bus.imem_addr !== 32'h100) begin bad++; $display("FAIL mis_set got m=%h a=%h exp=1/100", bus.misalign_err, bus.imem_addr); end
        tick();
        total++; if (bus.misalign_err !== 1'b0) begin bad++; $display("FAIL mis_clr got=%h exp=0", bus.misalign_err); end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        tick();
        bus.redirect = 1'b0;
        total++; if (bus.misalign_err !== 1'b0 || bus.imem_addr !== 32'h200) begin bad++; $display("FAIL mis_aligned got m=%h a=%h exp=0/200", bus.misalign_err, bus.imem_addr); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect = 1'b0;
        total++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_tgt got=%h exp=fffffffc", bus.imem_addr); end
        tick();
        total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=0", bus.imem_addr); end
        tick();
        total++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'hFFFF_FFFC || bus.id_pc_plus4 !== 32'h0 || bus.id_instr !== 32'h3) begin
            bad++;
            $display("FAIL wrap_id got v=%h pc=%h p4=%h i=%h exp=1/fffffffc/0/3",
                     bus.id_valid, bus.id_pc, bus.id_pc_plus4, bus.id_instr);
        end
        bus.stall = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        total++; if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_stall got v=%h a=%h r=%h exp=0/0/0", bus.id_valid, bus.imem_addr, bus.imem_req); end
        rst       = 1'b0;
        bus.stall = 1'b0;
        tick();
        tick();
        total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || bus.id_instr !== 32'h13) begin bad++; $display("FAIL rst_restart got v=%h pc=%h i=%h exp=1/0/13", bus.id_valid, bus.id_pc, bus.id_instr); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_misalign();
        test_wrap_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
